// File: rtl/int8_dual_requant_if.sv
// int8_dual_requant_if: pair-in / byte-out streams of the requant drain stage.
//   in_valid/in_ready/in_y/in_z  : accumulator pair stream (producer -> block)
//   out_valid/out_ready/out_data/out_last : serialized int8 stream (block -> consumer)
//   slave modport is the block's view, master is the producer/consumer view.
interface int8_dual_requant_if #(
    parameter int ACC_BITS = 32,
    parameter int OUT_BITS = 8
);
    logic                in_valid;
    logic                in_ready;
    logic [ACC_BITS-1:0] in_y;
    logic [ACC_BITS-1:0] in_z;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_BITS-1:0] out_data;
    logic                out_last;

    modport slave (
        input  in_valid, in_y, in_z, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_y, in_z, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/int8_dual_requant.sv
// int8_dual_requant: bias + fixed-point multiply + rounding shift + int8 clamp on
// (y, z) accumulator pairs, buffered and serialized y-then-z onto one int8 stream.
//   clk, rst (async, active low), bus (slave modport of int8_dual_requant_if),
//   cfg_bias_y/cfg_bias_z, cfg_mult, cfg_shift: captured with each accepted pair.
module int8_dual_requant #(
    parameter int ACC_BITS   = 32,
    parameter int MULT_BITS  = 16,
    parameter int SHIFT_BITS = 6,
    parameter int OUT_BITS   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    int8_dual_requant_if.slave    bus,
    input  logic [ACC_BITS-1:0]   cfg_bias_y,
    input  logic [ACC_BITS-1:0]   cfg_bias_z,
    input  logic [MULT_BITS-1:0]  cfg_mult,
    input  logic [SHIFT_BITS-1:0] cfg_shift
);
    localparam int P  = ACC_BITS + MULT_BITS;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic signed [P:0] OMAX = (P+1)'(2 ** (OUT_BITS - 1) - 1);
    localparam logic signed [P:0] OMIN = ~OMAX;

    typedef enum logic {EMIT_Y, EMIT_Z} state_t;

    function automatic logic [ACC_BITS-1:0] sat_add(input logic [ACC_BITS-1:0] a, input logic [ACC_BITS-1:0] b);
        logic [ACC_BITS:0] s;
        s = {a[ACC_BITS-1], a} + {b[ACC_BITS-1], b};
        // Top two bits disagree only on overflow; the true sign picks the rail.
        return (s[ACC_BITS] != s[ACC_BITS-1]) ? {s[ACC_BITS], {(ACC_BITS-1){~s[ACC_BITS]}}} : s[ACC_BITS-1:0];
    endfunction

    function automatic logic [P-1:0] mul(input logic [ACC_BITS-1:0] b, input logic [MULT_BITS-1:0] m);
        return $signed({{MULT_BITS{b[ACC_BITS-1]}}, b}) * $signed({{ACC_BITS{1'b0}}, m});
    endfunction

    function automatic logic [OUT_BITS-1:0] requant(input logic [P-1:0] p, input logic [SHIFT_BITS-1:0] sh);
        logic [P:0]        rnd;
        logic signed [P:0] r;
        rnd = (sh == '0) ? '0 : ({{P{1'b0}}, 1'b1} << (sh - 1'b1));
        // One guard bit so the rounding add cannot wrap before the shift.
        r = $signed({p[P-1], p} + rnd) >>> sh;
        return (r > OMAX) ? OMAX[OUT_BITS-1:0] : (r < OMIN) ? OMIN[OUT_BITS-1:0] : r[OUT_BITS-1:0];
    endfunction

    logic                  s1_v_q, s1_v_d, s2_v_q, s2_v_d, s3_v_q, s3_v_d;
    logic [ACC_BITS-1:0]   s1_by_q, s1_by_d, s1_bz_q, s1_bz_d;
    logic [MULT_BITS-1:0]  s1_mult_q, s1_mult_d;
    logic [SHIFT_BITS-1:0] s1_shift_q, s1_shift_d, s2_shift_q, s2_shift_d;
    logic [P-1:0]          s2_py_q, s2_py_d, s2_pz_q, s2_pz_d;
    logic [OUT_BITS-1:0]   s3_oy_q, s3_oy_d, s3_oz_q, s3_oz_d;
    logic [OUT_BITS-1:0]   mem_y_q [FIFO_DEPTH];
    logic [OUT_BITS-1:0]   mem_y_d [FIFO_DEPTH];
    logic [OUT_BITS-1:0]   mem_z_q [FIFO_DEPTH];
    logic [OUT_BITS-1:0]   mem_z_d [FIFO_DEPTH];
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d, occ;
    state_t                state_q, state_d;
    logic                  in_ready, accept, out_valid, pop;

    // Credits cover both buffered and in-flight pairs, so the pipeline never
    // has to stall and a write always finds a free slot.
    assign occ       = count_q + CW'(s1_v_q) + CW'(s2_v_q) + CW'(s3_v_q);
    assign in_ready  = occ < CW'(FIFO_DEPTH);
    assign accept    = bus.in_valid && in_ready;
    assign out_valid = (state_q == EMIT_Z) || (count_q != '0);
    assign pop       = (state_q == EMIT_Z) && bus.out_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_last  = state_q == EMIT_Z;
    assign bus.out_data  = (state_q == EMIT_Z) ? mem_z_q[rd_ptr_q] : mem_y_q[rd_ptr_q];

    always_comb begin
        s1_v_d     = accept;
        s1_by_d    = sat_add(bus.in_y, cfg_bias_y);
        s1_bz_d    = sat_add(bus.in_z, cfg_bias_z);
        s1_mult_d  = cfg_mult;
        s1_shift_d = cfg_shift;
        s2_v_d     = s1_v_q;
        s2_py_d    = mul(s1_by_q, s1_mult_q);
        s2_pz_d    = mul(s1_bz_q, s1_mult_q);
        s2_shift_d = s1_shift_q;
        s3_v_d     = s2_v_q;
        s3_oy_d    = requant(s2_py_q, s2_shift_q);
        s3_oz_d    = requant(s2_pz_q, s2_shift_q);
        mem_y_d    = mem_y_q;
        mem_z_d    = mem_z_q;
        if (s3_v_q) begin
            mem_y_d[wr_ptr_q] = s3_oy_q;
            mem_z_d[wr_ptr_q] = s3_oz_q;
        end
        wr_ptr_d = wr_ptr_q + AW'(s3_v_q);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(s3_v_q) - CW'(pop);
        state_d  = (state_q == EMIT_Y && out_valid && bus.out_ready) ? EMIT_Z : pop ? EMIT_Y : state_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_v_q     <= 1'b0;
            s2_v_q     <= 1'b0;
            s3_v_q     <= 1'b0;
            s1_by_q    <= '0;
            s1_bz_q    <= '0;
            s1_mult_q  <= '0;
            s1_shift_q <= '0;
            s2_py_q    <= '0;
            s2_pz_q    <= '0;
            s2_shift_q <= '0;
            s3_oy_q    <= '0;
            s3_oz_q    <= '0;
            mem_y_q    <= '{default: '0};
            mem_z_q    <= '{default: '0};
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= EMIT_Y;
        end else begin
            s1_v_q     <= s1_v_d;
            s2_v_q     <= s2_v_d;
            s3_v_q     <= s3_v_d;
            s1_by_q    <= s1_by_d;
            s1_bz_q    <= s1_bz_d;
            s1_mult_q  <= s1_mult_d;
            s1_shift_q <= s1_shift_d;
            s2_py_q    <= s2_py_d;
            s2_pz_q    <= s2_pz_d;
            s2_shift_q <= s2_shift_d;
            s3_oy_q    <= s3_oy_d;
            s3_oz_q    <= s3_oz_d;
            mem_y_q    <= mem_y_d;
            mem_z_q    <= mem_z_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
        end
    end
endmodule

// File: tb/tb_int8_dual_requant.sv
// tb_int8_dual_requant: directed and randomized checks of int8_dual_requant against an integer reference model.
module tb_int8_dual_requant;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cfg_bias_y, cfg_bias_z;
    logic [15:0] cfg_mult;
    logic [5:0]  cfg_shift;

    always #5 clk = ~clk;

    int8_dual_requant_if #(.ACC_BITS(32), .OUT_BITS(8)) bus();

    int8_dual_requant #(
        .ACC_BITS(32), .MULT_BITS(16), .SHIFT_BITS(6), .OUT_BITS(8), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave),
        .cfg_bias_y(cfg_bias_y),
        .cfg_bias_z(cfg_bias_z),
        .cfg_mult(cfg_mult),
        .cfg_shift(cfg_shift)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [8:0] exp_q[$];
    int         outstanding = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Plain integer arithmetic: saturating bias add, multiply, round-half-up shift, int8 clamp.
    function automatic logic [7:0] ref_lane(input longint acc, input longint bias, input longint mult, input int sh);
        longint b, p, r, lmax, lmin;
        lmax = (longint'(1) <<< 31) - 1;
        lmin = -(longint'(1) <<< 31);
        b = acc + bias;
        if (b > lmax) b = lmax;
        if (b < lmin) b = lmin;
        p = b * mult;
        r = (sh > 0) ? ((p + (longint'(1) <<< (sh - 1))) >>> sh) : p;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r[7:0];
    endfunction

    function automatic logic [31:0] rand_acc();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'($urandom_range(0, 4000)) - 32'd2000;
            2: return 32'h7FFF_FF00 + 32'($urandom_range(0, 255));
            default: return 32'h8000_0000 + 32'($urandom_range(0, 255));
        endcase
    endfunction

    // Observes the handshakes that the coming rising edge will complete.
    task automatic monitor();
        logic [8:0] e;
        if (!rst) begin
            exp_q.delete();
            outstanding = 0;
            return;
        end
        check("in_ready", longint'(bus.in_ready), longint'(outstanding < 4));
        if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back({1'b0, ref_lane(longint'($signed(bus.in_y)), longint'($signed(cfg_bias_y)), longint'(cfg_mult), int'(cfg_shift))});
            exp_q.push_back({1'b1, ref_lane(longint'($signed(bus.in_z)), longint'($signed(cfg_bias_z)), longint'(cfg_mult), int'(cfg_shift))});
            outstanding++;
        end
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", longint'(bus.out_valid), 0);
            end else begin
                e = exp_q.pop_front();
                check("out_data", longint'(bus.out_data), longint'(e[7:0]));
                check("out_last", longint'(bus.out_last), longint'(e[8]));
                if (e[8]) outstanding--;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pair(input logic [31:0] y, input logic [31:0] z);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_y     = y;
        bus.in_z     = z;
        for (int i = 0; i < 100 && !ok; i++) begin
            ok = bus.in_ready;
            tick();
        end
        bus.in_valid = 1'b0;
        if (!ok) check("send_timeout", longint'(ok), 1);
    endtask

    task automatic wait_out();
        for (int i = 0; i < 50 && !bus.out_valid; i++) tick();
        check("out_valid_seen", longint'(bus.out_valid), 1);
    endtask

    task automatic send_expect(input logic [31:0] y, input logic [31:0] z, input logic [7:0] ey, input logic [7:0] ez);
        bus.out_ready = 1'b1;
        send_pair(y, z);
        wait_out();
        check("y_data", longint'(bus.out_data), longint'(ey));
        check("y_last", longint'(bus.out_last), 0);
        tick();
        check("z_data", longint'(bus.out_data), longint'(ez));
        check("z_last", longint'(bus.out_last), 1);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int outs;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_y      = '0;
        bus.in_z      = '0;
        bus.out_ready = 1'b0;
        cfg_bias_y    = '0;
        cfg_bias_z    = '0;
        cfg_mult      = 16'd1;
        cfg_shift     = '0;
        tick();
        tick();
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_out_data", longint'(bus.out_data), 0);
        check("rst_out_last", longint'(bus.out_last), 0);
        check("rst_in_ready", longint'(bus.in_ready), 1);
        rst = 1'b1;
        tick();

        bus.out_ready = 1'b1;
        send_pair(32'd100, -32'sd100);
        check("lat_n0", longint'(bus.out_valid), 0);
        tick();
        check("lat_n1", longint'(bus.out_valid), 0);
        tick();
        check("lat_n2", longint'(bus.out_valid), 0);
        tick();
        check("lat_n3_valid", longint'(bus.out_valid), 1);
        check("basic_y", longint'(bus.out_data), 8'h64);
        check("basic_y_last", longint'(bus.out_last), 0);
        tick();
        check("basic_z", longint'(bus.out_data), 8'h9C);
        check("basic_z_last", longint'(bus.out_last), 1);
        tick();
        check("basic_idle", longint'(bus.out_valid), 0);

        send_expect(32'd1000, -32'sd1000, 8'h7F, 8'h80);
        cfg_bias_y = 32'h100;
        cfg_shift  = 6'd24;
        send_expect(32'h7FFF_FFF0, 32'd0, 8'h7F, 8'h00);
        cfg_bias_y = '0;
        cfg_shift  = 6'd1;
        send_expect(32'd3, -32'sd3, 8'h02, 8'hFF);
        cfg_mult   = 16'd3;
        cfg_shift  = 6'd2;
        send_expect(32'd5, -32'sd5, 8'h04, 8'hFC);
        cfg_mult   = 16'd1;
        cfg_shift  = '0;

        bus.out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_y     = 32'(i * 10 + 1);
            bus.in_z     = -32'(i * 10 + 1);
            if (bus.in_ready) acc++;
            tick();
        end
        bus.in_valid = 1'b0;
        check("bp_accepted", acc, 4);
        check("bp_in_ready_low", longint'(bus.in_ready), 0);
        tick();
        tick();
        check("bp_in_ready_still_low", longint'(bus.in_ready), 0);
        outs = 0;
        bus.out_ready = 1'b1;
        check("bp_ready_before_pop", longint'(bus.in_ready), 0);
        if (bus.out_valid) outs++;
        tick();
        check("bp_ready_after_y", longint'(bus.in_ready), 0);
        if (bus.out_valid) outs++;
        tick();
        check("bp_ready_after_pop", longint'(bus.in_ready), 1);
        for (int i = 0; i < 40 && bus.out_valid; i++) begin
            outs++;
            tick();
        end
        check("bp_outputs", outs, 8);
        check("bp_drained", longint'(bus.out_valid), 0);

        bus.out_ready = 1'b0;
        send_pair(32'd55, -32'sd77);
        wait_out();
        check("stall_y", longint'(bus.out_data), 8'h37);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", longint'(bus.out_valid), 1);
            check("stall_data", longint'(bus.out_data), 8'hB3);
            check("stall_last", longint'(bus.out_last), 1);
        end
        bus.out_ready = 1'b1;
        tick();
        check("stall_done", longint'(bus.out_valid), 0);

        bus.out_ready = 1'b0;
        send_pair(32'd1, -32'sd1);
        send_pair(32'd2, -32'sd2);
        send_pair(32'd3, -32'sd3);
        for (int i = 0; i < 4; i++) tick();
        check("mid_buffered", longint'(bus.out_valid), 1);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", longint'(bus.out_valid), 0);
        check("mid_rst_in_ready", longint'(bus.in_ready), 1);
        check("mid_rst_last", longint'(bus.out_last), 0);
        tick();
        rst = 1'b1;
        tick();
        check("mid_post_idle", longint'(bus.out_valid), 0);
        send_expect(32'd7, -32'sd7, 8'h07, 8'hF9);

        acc = 0;
        for (int c = 0; c < 5000 && acc < 150; c++) begin
            bus.out_ready = ($urandom % 3) != 0;
            bus.in_valid  = ($urandom % 4) != 0;
            bus.in_y      = rand_acc();
            bus.in_z      = rand_acc();
            cfg_bias_y    = rand_acc();
            cfg_bias_z    = rand_acc();
            cfg_mult      = 16'($urandom);
            cfg_shift     = 6'($urandom_range(0, 47));
            if (bus.in_valid && bus.in_ready) acc++;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("rand_accepted", acc, 150);
        for (int i = 0; i < 400 && exp_q.size() > 0; i++) tick();
        tick();
        check("rand_drain_empty", exp_q.size(), 0);
        check("rand_idle", longint'(bus.out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
